// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sseg_pkg;
   localparam logic [6:0] SSEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF     = 8'hFF;
   localparam int         MAX_DIGITS = 8;
endpackage

// File: rtl/hex2sseg.sv
// Hex nibble to active-low gfedcba seven-segment glyph.
// Latency: combinational.
// Backpressure: none; pure decode.
module hex2sseg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   // Glyph table, active-low, bit 6 = g down to bit 0 = a
   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'h7F;
      endcase
   end
endmodule

// File: rtl/sseg_scanner.sv
// Multi-digit seven-segment scanner with frame-aligned value commit and leading-zero blanking.
// Latency: AN/sseg/DP registered (1 cycle); load becomes visible after at most one frame + 1 cycle.
// Backpressure: none; load is a strobe that is never stalled, later loads overwrite the shadow.
module sseg_scanner #(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = 100000,
   parameter int LZ_BLANK = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp_mask,
   output logic [7:0]          AN,
   output logic [6:0]          sseg,
   output logic                DP,
   output logic                pending,
   output logic                frame_done
);
   import sseg_pkg::*;

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [PW-1:0]           pcnt_q, pcnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*DIGITS-1:0]     shadow_q, shadow_d;
   logic [4*DIGITS-1:0]     disp_q, disp_d;
   logic                    pending_q, pending_d;
   logic                    fd_q, fd_d;
   logic [7:0]              an_q, an_d;
   logic [6:0]              sseg_q, sseg_d;
   logic                    dp_q, dp_d;

   logic                    tick, wrap;
   logic [2:0]              sel;
   logic [4*MAX_DIGITS-1:0] disp_ext;
   logic [MAX_DIGITS-1:0]   dp_ext;
   logic [MAX_DIGITS-1:0]   blank_vec;
   logic                    all_zero;
   logic                    blank_cur;
   logic [3:0]              cur_nib;
   logic [6:0]              glyph;

   assign tick = (pcnt_q == PMAX);
   assign wrap = tick && (idx_q == IMAX);
   assign sel  = 3'(idx_q);

   // Widen display value and dp mask to the full 8-digit space so selects never run out of range
   always_comb begin
      disp_ext                 = '0;
      disp_ext[4*DIGITS-1:0]   = disp_q;
      dp_ext                   = '0;
      dp_ext[DIGITS-1:0]       = dp_mask;
   end

   // Digit i blanks when it and every digit above it is zero; digit 0 always shows
   always_comb begin
      all_zero  = 1'b1;
      blank_vec = '0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         all_zero     = all_zero && (disp_ext[4*i +: 4] == 4'h0);
         blank_vec[i] = (LZ_BLANK != 0) && (i != 0) && all_zero;
      end
   end

   assign blank_cur = blank_vec[sel];
   assign cur_nib   = disp_ext[{sel, 2'b00} +: 4];

   hex2sseg u_hex2sseg (
      .hex (cur_nib),
      .seg (glyph)
   );

   // Scan counters, shadow capture, frame-boundary commit and next output drive
   always_comb begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      idx_d  = idx_q;
      if (tick) begin
         idx_d = (idx_q == IMAX) ? '0 : idx_q + IW'(1);
      end

      shadow_d  = load ? value : shadow_q;
      pending_d = pending_q;
      if (load) begin
         pending_d = 1'b1;
      end

      // A load coinciding with the wrap goes straight to the display
      disp_d = disp_q;
      if (wrap) begin
         pending_d = 1'b0;
         if (load) begin
            disp_d = value;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
      end

      fd_d = wrap;

      an_d   = AN_OFF;
      sseg_d = SSEG_BLANK;
      dp_d   = 1'b1;
      if (!blank_cur) begin
         an_d[sel] = 1'b0;
         sseg_d    = glyph;
         dp_d      = ~dp_ext[sel];
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pcnt_q    <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         fd_q      <= 1'b0;
         an_q      <= AN_OFF;
         sseg_q    <= SSEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         pcnt_q    <= pcnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         fd_q      <= fd_d;
         an_q      <= an_d;
         sseg_q    <= sseg_d;
         dp_q      <= dp_d;
      end
   end

   assign AN         = an_q;
   assign sseg       = sseg_q;
   assign DP         = dp_q;
   assign pending    = pending_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner: two instances (blanking on / off) share all inputs.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_sseg_scanner;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [31:0] value;
   logic        load;
   logic [7:0]  dp_mask;

   logic [7:0] an1, an0;
   logic [6:0] sseg1, sseg0;
   logic       dp1, dp0, pend1, pend0, fd1, fd0;

   sseg_scanner #(.DIGITS(8), .PRESCALE(4), .LZ_BLANK(1)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_mask(dp_mask),
      .AN(an1), .sseg(sseg1), .DP(dp1), .pending(pend1), .frame_done(fd1)
   );

   sseg_scanner #(.DIGITS(8), .PRESCALE(4), .LZ_BLANK(0)) dut_nb (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_mask(dp_mask),
      .AN(an0), .sseg(sseg0), .DP(dp0), .pending(pend0), .frame_done(fd0)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] val;
      int          dig;
      logic [7:0]  an1;
      logic [6:0]  s1;
      logic [7:0]  an0;
      logic [6:0]  s0;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fd();
      int k;
      k = 0;
      while (fd1 !== 1'b1 && k < 70) begin
         step(1);
         k++;
      end
      chk("frame_done_seen", fd1, 1);
   endtask

   task automatic pulse_load(input logic [31:0] v);
      value = v;
      load  = 1'b1;
      step(1);
      load  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cur;
      logic [7:0]  e;
      int          bad;
      int          d;

      tbl[0]  = '{32'h0000_00A5, 0, 8'hFE, 7'h12, 8'hFE, 7'h12};
      tbl[1]  = '{32'h0000_00A5, 1, 8'hFD, 7'h08, 8'hFD, 7'h08};
      tbl[2]  = '{32'h0000_00A5, 2, 8'hFF, 7'h7F, 8'hFB, 7'h40};
      tbl[3]  = '{32'h0000_00A5, 7, 8'hFF, 7'h7F, 8'h7F, 7'h40};
      tbl[4]  = '{32'h1234_5678, 0, 8'hFE, 7'h00, 8'hFE, 7'h00};
      tbl[5]  = '{32'h1234_5678, 1, 8'hFD, 7'h78, 8'hFD, 7'h78};
      tbl[6]  = '{32'h1234_5678, 2, 8'hFB, 7'h02, 8'hFB, 7'h02};
      tbl[7]  = '{32'h1234_5678, 3, 8'hF7, 7'h12, 8'hF7, 7'h12};
      tbl[8]  = '{32'h1234_5678, 4, 8'hEF, 7'h19, 8'hEF, 7'h19};
      tbl[9]  = '{32'h1234_5678, 5, 8'hDF, 7'h30, 8'hDF, 7'h30};
      tbl[10] = '{32'h1234_5678, 6, 8'hBF, 7'h24, 8'hBF, 7'h24};
      tbl[11] = '{32'h1234_5678, 7, 8'h7F, 7'h79, 8'h7F, 7'h79};
      tbl[12] = '{32'h0000_0000, 0, 8'hFE, 7'h40, 8'hFE, 7'h40};
      tbl[13] = '{32'h0000_0000, 1, 8'hFF, 7'h7F, 8'hFD, 7'h40};
      tbl[14] = '{32'h8000_0000, 1, 8'hFD, 7'h40, 8'hFD, 7'h40};
      tbl[15] = '{32'h8000_0000, 7, 8'h7F, 7'h00, 8'h7F, 7'h00};
      tbl[16] = '{32'hFEDC_BA90, 1, 8'hFD, 7'h10, 8'hFD, 7'h10};
      tbl[17] = '{32'hFEDC_BA90, 2, 8'hFB, 7'h08, 8'hFB, 7'h08};
      tbl[18] = '{32'hFEDC_BA90, 3, 8'hF7, 7'h03, 8'hF7, 7'h03};
      tbl[19] = '{32'hFEDC_BA90, 4, 8'hEF, 7'h46, 8'hEF, 7'h46};
      tbl[20] = '{32'hFEDC_BA90, 5, 8'hDF, 7'h21, 8'hDF, 7'h21};
      tbl[21] = '{32'hFEDC_BA90, 6, 8'hBF, 7'h06, 8'hBF, 7'h06};
      tbl[22] = '{32'hFEDC_BA90, 7, 8'h7F, 7'h0E, 8'h7F, 7'h0E};

      reset_n = 1'b0;
      value   = 32'h0;
      load    = 1'b0;
      dp_mask = 8'h00;

      // Reset state
      step(3);
      chk("rst_an", an1, 8'hFF);
      chk("rst_sseg", sseg1, 7'h7F);
      chk("rst_dp", dp1, 1);
      chk("rst_pending", pend1, 0);
      chk("rst_fd", fd1, 0);

      // First edge after release, then the scan walk
      reset_n = 1'b1;
      step(1);
      chk("rel_an", an1, 8'hFE);
      chk("rel_sseg", sseg1, 7'h40);
      chk("rel_dp", dp1, 1);
      chk("rel_fd", fd1, 0);
      for (int i = 1; i < 8; i++) begin
         step(4);
         e = 8'hFF;
         e[i] = 1'b0;
         chk($sformatf("scan_an_nb_d%0d", i), an0, e);
         chk($sformatf("scan_an_lz_d%0d", i), an1, 8'hFF);
      end
      step(2);
      chk("fd_before_wrap", fd1, 0);
      step(1);
      chk("fd_at_32", fd1, 1);
      step(1);
      chk("fd_after_wrap", fd1, 0);
      chk("an_frame2_d0", an1, 8'hFE);
      step(31);
      chk("fd_at_64", fd1, 1);

      // Table-driven glyph / anode / blanking checks
      cur = 32'hFFFF_FFFF;
      for (int i = 0; i < 23; i++) begin
         if (tbl[i].val != cur) begin
            pulse_load(tbl[i].val);
            cur = tbl[i].val;
         end
         wait_fd();
         step(1 + 4 * tbl[i].dig);
         chk($sformatf("tbl%0d_an_lz", i), an1, tbl[i].an1);
         chk($sformatf("tbl%0d_sseg_lz", i), sseg1, tbl[i].s1);
         chk($sformatf("tbl%0d_an_nb", i), an0, tbl[i].an0);
         chk($sformatf("tbl%0d_sseg_nb", i), sseg0, tbl[i].s0);
         chk($sformatf("tbl%0d_dp", i), dp1, 1);
      end

      // Two loads in one frame: last wins, no tearing
      wait_fd();
      step(1);
      pulse_load(32'h1111_1111);
      chk("dbl_pending_first", pend1, 1);
      step(3);
      pulse_load(32'h2222_2222);
      bad = 0;
      for (int k = 0; k < 40 && fd1 !== 1'b1; k++) begin
         if (sseg1 == 7'h79 || pend1 !== 1'b1) bad++;
         step(1);
      end
      chk("dbl_no_ones_pending_held", bad, 0);
      chk("dbl_fd", fd1, 1);
      chk("dbl_pending_clear", pend1, 0);
      step(1);
      chk("dbl_d0_an", an1, 8'hFE);
      chk("dbl_d0_sseg", sseg1, 7'h24);
      step(4);
      chk("dbl_d1_an", an1, 8'hFD);
      chk("dbl_d1_sseg", sseg1, 7'h24);
      step(24);
      chk("dbl_d7_an", an1, 8'h7F);
      chk("dbl_d7_sseg", sseg1, 7'h24);

      // Load in the same cycle as wrap
      wait_fd();
      step(31);
      chk("lw_pending_before", pend1, 0);
      pulse_load(32'h0000_0008);
      chk("lw_fd_aligned", fd1, 1);
      chk("lw_pending_after", pend1, 0);
      step(1);
      chk("lw_d0_an", an1, 8'hFE);
      chk("lw_d0_sseg", sseg1, 7'h00);
      bad = 0;
      for (int k = 1; k < 32; k++) begin
         step(1);
         if (pend1 !== 1'b0) bad++;
         if (k == 4) chk("lw_d1_blank", an1, 8'hFF);
      end
      chk("lw_pending_never", bad, 0);

      // Decimal point on digit 2 with a zero display
      pulse_load(32'h0000_0000);
      wait_fd();
      dp_mask = 8'h04;
      for (int k = 0; k < 32; k++) begin
         step(1);
         d = k / 4;
         e = 8'hFF;
         e[d] = 1'b0;
         chk($sformatf("dp_an_nb_k%0d", k), an0, e);
         chk($sformatf("dp_nb_k%0d", k), dp0, (d == 2) ? 0 : 1);
         chk($sformatf("dp_lz_k%0d", k), dp1, 1);
      end
      dp_mask = 8'h00;

      // Reset while a value is pending
      wait_fd();
      step(2);
      pulse_load(32'h0000_0077);
      chk("rp_pending", pend1, 1);
      reset_n = 1'b0;
      step(1);
      chk("rp_an_off", an1, 8'hFF);
      chk("rp_sseg_off", sseg1, 7'h7F);
      chk("rp_pending_clr", pend1, 0);
      chk("rp_fd", fd1, 0);
      reset_n = 1'b1;
      step(1);
      chk("rp_rel_an", an1, 8'hFE);
      chk("rp_rel_sseg", sseg1, 7'h40);
      bad = 0;
      for (int k = 1; k < 64; k++) begin
         step(1);
         if (sseg1 == 7'h78 || sseg1 == 7'h00 || pend1 !== 1'b0) bad++;
         if (fd1 !== ((((k + 1) % 32) == 0) ? 1'b1 : 1'b0)) bad++;
      end
      chk("rp_old_value_gone", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sseg_scanner.md
# sseg_scanner

Time-multiplexed seven-segment display driver: the consumer end of the accumulator/register datapath. It captures a hex value on a load strobe into a shadow register, commits it to the display register only at frame boundaries so digits never tear, and scans it across `DIGITS` common-anode digits with optional leading-zero blanking. It replaces the fixed single-digit anode tie-off with a real multi-digit refresh.

## Interface
Parameters:
- `DIGITS`, 8: number of digits scanned; value width is `4*DIGITS`; legal range 1..8.
- `PRESCALE`, 100000: clk cycles each digit stays lit; minimum 2.
- `LZ_BLANK`, 1: 1 enables leading-zero blanking; 0 shows all digits.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `value`  in  4*DIGITS  hex value to display; nibble i drives digit i, with digit 0 rightmost.
- `load`  in  1  one-cycle strobe, already debounced; captures `value`.
- `dp_mask`  in  DIGITS  bit i=1 lights the decimal point on digit i; sampled live, not buffered.
- `AN`  out  8  anode enables, active-low; bits at `DIGITS` and above are held at 1.
- `sseg`  out  7  segments gfedcba, active-low.
- `DP`  out  1  decimal point, active-low.
- `pending`  out  1  a captured value is waiting for a frame boundary.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1. `tick` is asserted when `pcnt==PRESCALE-1`; `pcnt` then returns to 0.
- On `tick`, digit index `idx` advances; it wraps from DIGITS-1 to 0.
- `wrap` = `tick && idx==DIGITS-1`.
- On `load`: `shadow<=value` and `pending<=1`. A later `load` before the boundary overwrites `shadow`; the last value wins.
- On `wrap`:
  - If `load` is asserted in the same cycle, `disp<=value` directly.
  - Otherwise, if `pending` is set, `disp<=shadow`.
  - In either case `pending<=0`.
- `frame_done` is registered and equals the `wrap` of the previous cycle.
- Digit i is blank when `LZ_BLANK==1`, `i!=0`, and nibbles i..DIGITS-1 of `disp` are all zero. Digit 0 is never blank, so value 0 shows a single "0".
- For the active digit `idx`:
  - `AN` has bit `idx` = 0 and all other bits = 1. A blank digit drives `AN` all 1s.
  - `sseg` = hex2sseg(`disp` nibble `idx`). A blank digit drives 7'h7F.
  - `DP` = ~`dp_mask[idx]`. A blank digit drives 1.
- Hex glyphs follow the active-low gfedcba encoding, e.g. 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, F→7'b0001110.

## Timing
- `AN`, `sseg` and `DP` are registered, so they show `idx`/`disp` from the previous cycle (1-cycle latency).
- While `reset_n` is low, on each clock edge: `pcnt=0`, `idx=0`, `disp=0`, `shadow=0`, `pending=0`, `frame_done=0`, `AN=8'hFF`, `sseg=7'h7F`, `DP=1`.
- On the first edge after reset release, `AN=8'hFE` and `sseg=7'b1000000`.
- Each digit is lit for exactly `PRESCALE` cycles, and a frame lasts `DIGITS*PRESCALE` cycles.
- Worst-case latency from `load` to visible: one full frame plus 1 cycle.
- Reset asserted mid-frame or while `pending` is set discards `shadow` and `disp`. It does not generate a `frame_done`.
- When `load` and `wrap` occur together, `pending` ends at 0 and `disp` takes `value`. `shadow` also takes `value`.
- `DIGITS==1`: `wrap` equals `tick`, and `AN=8'hFE` is constant after reset.

## Structure
- Shared package `sseg_pkg` holds:
  - `SSEG_BLANK` = 7'h7F
  - `AN_OFF` = 8'hFF
  - `MAX_DIGITS` = 8
- The package exports no typedefs beyond these constants.
- Single sub-module: the existing `hex2sseg` (4-bit hex in, 7-bit active-low sseg out), instantiated once on the selected nibble.
- Width of `pcnt` is $clog2(PRESCALE). Width of `idx` is max(1,$clog2(DIGITS)).

## Test plan
All scenarios use `DIGITS=8` and `PRESCALE=4` unless noted.
- Reset release: after reset, `AN=FE`, `sseg=40`, and `DP=1`. `AN` then steps FE→FD→…→7F every 4 cycles, and `frame_done` pulses every 32 cycles.
- Load 32'h0000_00A5 with `LZ_BLANK=1`: after the next `frame_done`:
  - digit 0 shows 5 (7'b0010010) and digit 1 shows A (7'b0001000);
  - digits 2–7 have `AN=FF` and `sseg=7F`.
- Loads of 32'h1111_1111 then 32'h2222_2222 within one frame: the display never shows 1s. `pending` stays 1 until the wrap, and the display then shows 2 on all digits.
- `load` of 32'h8 in the same cycle as `wrap`: the next frame shows 8 on digit 0, and `pending` remains 0 throughout.
- `dp_mask=8'h04` with `disp=0` and `LZ_BLANK=0`: `DP=0` only while `AN=FB`. With `LZ_BLANK=1`, `DP` stays 1 on digit 2 because the digit is blank.
- `reset_n` low for one cycle with `pending=1`: the next cycle shows `AN=FF`. After release, `disp=0` and `pending=0`, and the old value never appears.
